// File: rtl/aes_mixcol_iter_if.sv
// Handshake bundle for aes_mixcol_iter.
// Input side: a state transfers on a rising edge where valid_i && ready_o. The
// producer holds valid_i, inv_i and state_i steady until then. Output side: a
// result transfers on a rising edge where valid_o && ready_i. valid_o and
// state_o do not change until that edge.
interface aes_mixcol_iter_if;
  logic         valid_i;
  logic         ready_o;
  logic         inv_i;
  logic [127:0] state_i;
  logic         valid_o;
  logic         ready_i;
  logic [127:0] state_o;
  logic         busy_o;

  modport slave (
    input  valid_i, inv_i, state_i, ready_i,
    output ready_o, valid_o, state_o, busy_o
  );

  modport master (
    output valid_i, inv_i, state_i, ready_i,
    input  ready_o, valid_o, state_o, busy_o
  );
endinterface

// File: rtl/aes_mixcol_iter.sv
// Iterative AES MixColumns over a 128-bit state, COLS_PER_CYC columns per beat.
// Define AES_MIXCOL_INV_EN to add the InvMixColumns datapath, selected by inv_i
// for each transaction. Without it, inv_i is ignored and the block always runs
// the forward transform.
module aes_mixcol_iter #(
  parameter int COLS_PER_CYC = 1
) (
  input logic              clk_i,
  input logic              rst_i,
  aes_mixcol_iter_if.slave bus
);
  localparam int NBEAT = 4 / COLS_PER_CYC;

  if (COLS_PER_CYC != 1 && COLS_PER_CYC != 2 && COLS_PER_CYC != 4) begin : g_bad_cols
    $error("aes_mixcol_iter: COLS_PER_CYC must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t       state_q, state_d;
  logic [1:0]   cnt_q;
  logic [127:0] work_q;
  logic [127:0] result_q;
  logic         accept;
  logic         last_beat;
  logic [31:0]  beat_cols [COLS_PER_CYC];
`ifdef AES_MIXCOL_INV_EN
  logic         inv_q;
`else
  logic         unused_inv;
  assign unused_inv = bus.inv_i;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] b0, b1, b2, b3, x0, x1, x2, x3;
    b0 = c[7:0];   b1 = c[15:8];  b2 = c[23:16]; b3 = c[31:24];
    x0 = xtime(b0); x1 = xtime(b1); x2 = xtime(b2); x3 = xtime(b3);
    return {x0 ^ b0 ^ b1 ^ b2 ^ x3,
            b0 ^ b1 ^ x2 ^ x3 ^ b3,
            b0 ^ x1 ^ x2 ^ b2 ^ b3,
            x0 ^ x1 ^ b1 ^ b2 ^ b3};
  endfunction

`ifdef AES_MIXCOL_INV_EN
  // Each byte gets its x9/xb/xd/xe multiples, built from chained xtime.
  // Output row r then uses coefficients [0e 0b 0d 09] rotated right by r.
  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] b, x2, x4, x8;
    logic [31:0] o;
    o = '0;
    for (int j = 0; j < 4; j++) begin
      b  = c[8*j +: 8];
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      m9[j] = x8 ^ b;
      mb[j] = x8 ^ x2 ^ b;
      md[j] = x8 ^ x4 ^ b;
      me[j] = x8 ^ x4 ^ x2;
    end
    for (int r = 0; r < 4; r++) begin
      o[8*r +: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
    return o;
  endfunction
`endif

  assign bus.ready_o = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.ready_i);
  assign bus.valid_o = (state_q == ST_DONE);
  assign bus.busy_o  = (state_q == ST_BUSY);
  assign bus.state_o = result_q;
  assign accept      = bus.valid_i && bus.ready_o;
  assign last_beat   = (cnt_q == 2'(NBEAT - 1));

  // Next-state logic: IDLE -> BUSY on accept, BUSY -> DONE after the last beat,
  // DONE -> BUSY (new accept) or IDLE when the result is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (last_beat) state_d = ST_DONE;
      ST_DONE: if (bus.ready_i) state_d = accept ? ST_BUSY : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Transform the columns that belong to the current beat
  always_comb begin
    for (int k = 0; k < COLS_PER_CYC; k++) begin
`ifdef AES_MIXCOL_INV_EN
      beat_cols[k] = inv_q
        ? mix_inv(work_q[7'(32*(int'(cnt_q)*COLS_PER_CYC + k)) +: 32])
        : mix_fwd(work_q[7'(32*(int'(cnt_q)*COLS_PER_CYC + k)) +: 32]);
`else
      beat_cols[k] = mix_fwd(work_q[7'(32*(int'(cnt_q)*COLS_PER_CYC + k)) +: 32]);
`endif
    end
  end

  // Datapath: latch work state on accept, write result columns on each BUSY beat
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
`ifdef AES_MIXCOL_INV_EN
      inv_q    <= 1'b0;
`endif
    end else if (accept) begin
      cnt_q  <= '0;
      work_q <= bus.state_i;
`ifdef AES_MIXCOL_INV_EN
      inv_q  <= bus.inv_i;
`endif
    end else if (state_q == ST_BUSY) begin
      cnt_q <= cnt_q + 2'd1;
      for (int k = 0; k < COLS_PER_CYC; k++) begin
        result_q[7'(32*(int'(cnt_q)*COLS_PER_CYC + k)) +: 32] <= beat_cols[k];
      end
    end
  end
endmodule

// File: tb/tb_aes_mixcol_iter.sv
// Testbench for aes_mixcol_iter: known vectors, random states against a GF(2^8)
// matrix model, back-pressure, back-to-back transfers and mid-operation reset.
module tb_aes_mixcol_iter;
  parameter int COLS = 1;
  localparam int NBEAT = 4 / COLS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_mixcol_iter_if bus();

  aes_mixcol_iter #(.COLS_PER_CYC(COLS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q[$];

  // Polynomial multiply, then reduce modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // MixColumns as a circulant matrix product per column
  function automatic logic [127:0] ref_state(input logic [127:0] s, input logic inv);
    logic [7:0] coef [4];
    logic [127:0] res;
    logic [7:0] acc;
    logic use_inv;
`ifdef AES_MIXCOL_INV_EN
    use_inv = inv;
`else
    use_inv = inv & 1'b0;
`endif
    if (use_inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else         coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - r + 4) % 4], s[32*c + 8*j +: 8]);
        res[32*c + 8*r +: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_and_check(input logic [127:0] s, input logic inv, input string name,
                                output logic [127:0] got);
    int waitc;
    int lat;
    logic [127:0] exp;
    waitc = 0;
    while (!bus.ready_o && waitc < 50) begin
      @(posedge clk); #1; waitc++;
    end
    total++;
    if (bus.ready_o !== 1'b1) begin
      bad++; $display("FAIL %s_ready got=%b want=1", name, bus.ready_o);
    end
    bus.valid_i = 1'b1;
    bus.state_i = s;
    bus.inv_i   = inv;
    exp_q.push_back(ref_state(s, inv));
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.state_i = rand_state();
    bus.inv_i   = 1'($urandom);
    lat = 0;
    while (!bus.valid_o && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    total++;
    if (lat != NBEAT) begin
      bad++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, NBEAT);
    end
    exp = exp_q.pop_front();
    total++;
    if (bus.state_o !== exp) begin
      bad++; $display("FAIL %s_result got=%h want=%h", name, bus.state_o, exp);
    end
    got = bus.state_o;
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    total++;
    if ({bus.valid_o, bus.ready_o} !== 2'b01) begin
      bad++; $display("FAIL %s_drain got={valid,ready}=%b want=01", name, {bus.valid_o, bus.ready_o});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    total++;
    if ({bus.valid_o, bus.ready_o, bus.busy_o} !== 3'b010) begin
      bad++; $display("FAIL reset_flags got={valid,ready,busy}=%b want=010",
                      {bus.valid_o, bus.ready_o, bus.busy_o});
    end
    total++;
    if (bus.state_o !== 128'h0) begin
      bad++; $display("FAIL reset_state got=%h want=0", bus.state_o);
    end
  endtask

  task automatic test_vectors();
    logic [127:0] got;
    send_and_check({96'h0, 32'h455313db}, 1'b0, "vec1", got);
    total++;
    if (got !== {96'h0, 32'hbca14d8e}) begin
      bad++; $display("FAIL vec1_const got=%h want=%h", got, {96'h0, 32'hbca14d8e});
    end
    send_and_check({32'hd5d4d4d4, 32'h01010101, 32'hc6c6c6c6, 32'h5c220af2}, 1'b0, "vec2", got);
    total++;
    if (got !== {32'hd6d7d5d5, 32'h01010101, 32'hc6c6c6c6, 32'h9d58dc9f}) begin
      bad++; $display("FAIL vec2_const got=%h want=%h", got,
                      {32'hd6d7d5d5, 32'h01010101, 32'hc6c6c6c6, 32'h9d58dc9f});
    end
  endtask

  task automatic test_inverse();
    logic [127:0] got;
    logic [127:0] s;
    logic [127:0] f;
`ifdef AES_MIXCOL_INV_EN
    send_and_check({96'h0, 32'hbca14d8e}, 1'b1, "inv_vec", got);
    total++;
    if (got !== {96'h0, 32'h455313db}) begin
      bad++; $display("FAIL inv_vec_const got=%h want=%h", got, {96'h0, 32'h455313db});
    end
    for (int i = 0; i < 150; i++) begin
      s = rand_state();
      send_and_check(s, 1'b0, "rt_fwd", f);
      send_and_check(f, 1'b1, "rt_inv", got);
      total++;
      if (got !== s) begin
        bad++; $display("FAIL roundtrip got=%h want=%h", got, s);
      end
    end
`else
    send_and_check({96'h0, 32'h455313db}, 1'b1, "inv_ignored", got);
    total++;
    if (got !== {96'h0, 32'hbca14d8e}) begin
      bad++; $display("FAIL inv_ignored_const got=%h want=%h", got, {96'h0, 32'hbca14d8e});
    end
`endif
  endtask

  task automatic test_random();
    logic [127:0] got;
    for (int i = 0; i < 100; i++) begin
      send_and_check(rand_state(), 1'($urandom), "random", got);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] s;
    logic [127:0] s2;
    logic [127:0] exp;
    int lat;
    s = rand_state();
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.state_i = s;
    bus.inv_i   = 1'b0;
    exp = ref_state(s, 1'b0);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    lat = 0;
    while (!bus.valid_o && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    total++;
    if (lat != NBEAT) begin
      bad++; $display("FAIL bp_latency got=%0d want=%0d", lat, NBEAT);
    end
    bus.valid_i = 1'b1;
    bus.state_i = rand_state();
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({bus.valid_o, bus.ready_o, bus.busy_o} !== 3'b100) begin
        bad++; $display("FAIL bp_hold_flags cyc=%0d got={valid,ready,busy}=%b want=100", i,
                        {bus.valid_o, bus.ready_o, bus.busy_o});
      end
      total++;
      if (bus.state_o !== exp) begin
        bad++; $display("FAIL bp_hold_state cyc=%0d got=%h want=%h", i, bus.state_o, exp);
      end
      @(posedge clk); #1;
    end
    s2 = bus.state_i;
    bus.ready_i = 1'b1;
    #1;
    total++;
    if (bus.ready_o !== 1'b1) begin
      bad++; $display("FAIL bp_release_ready got=%b want=1", bus.ready_o);
    end
    exp = ref_state(s2, 1'b0);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    total++;
    if ({bus.valid_o, bus.busy_o} !== 2'b01) begin
      bad++; $display("FAIL bp_no_bubble got={valid,busy}=%b want=01", {bus.valid_o, bus.busy_o});
    end
    lat = 0;
    while (!bus.valid_o && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    total++;
    if (lat != NBEAT) begin
      bad++; $display("FAIL bp2_latency got=%0d want=%0d", lat, NBEAT);
    end
    total++;
    if (bus.state_o !== exp) begin
      bad++; $display("FAIL bp2_result got=%h want=%h", bus.state_o, exp);
    end
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
  endtask

  task automatic test_midreset();
    logic [127:0] got;
    bus.valid_i = 1'b1;
    bus.state_i = rand_state();
    bus.inv_i   = 1'b0;
    bus.ready_i = 1'b0;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({bus.valid_o, bus.ready_o, bus.busy_o} !== 3'b010) begin
      bad++; $display("FAIL midrst_flags got={valid,ready,busy}=%b want=010",
                      {bus.valid_o, bus.ready_o, bus.busy_o});
    end
    total++;
    if (bus.state_o !== 128'h0) begin
      bad++; $display("FAIL midrst_state got=%h want=0", bus.state_o);
    end
    send_and_check(rand_state(), 1'($urandom), "after_rst", got);
  endtask

  task automatic test_back_to_back();
    logic [127:0] st [6];
    logic [127:0] exp;
    int idx;
    int outs;
    int cyc;
    int last_acc;
    idx = 0; outs = 0; cyc = 0; last_acc = -1;
    for (int i = 0; i < 6; i++) st[i] = rand_state();
    bus.ready_i = 1'b1;
    while (outs < 6 && cyc < 200) begin
      bus.valid_i = (idx < 6);
      if (idx < 6) begin
        bus.state_i = st[idx];
        bus.inv_i   = 1'($urandom);
      end
      #1;
      if (bus.valid_o) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra got=%h want=none", bus.state_o);
        end else begin
          exp = exp_q.pop_front();
          if (bus.state_o !== exp) begin
            bad++; $display("FAIL b2b_result n=%0d got=%h want=%h", outs, bus.state_o, exp);
          end
        end
        outs++;
      end
      if (bus.valid_i && bus.ready_o) begin
        exp_q.push_back(ref_state(st[idx], bus.inv_i));
        if (last_acc >= 0) begin
          total++;
          if (cyc - last_acc != NBEAT + 1) begin
            bad++; $display("FAIL b2b_gap got=%0d want=%0d", cyc - last_acc, NBEAT + 1);
          end
        end
        last_acc = cyc;
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (outs != 6) begin
      bad++; $display("FAIL b2b_count got=%0d want=6", outs);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.inv_i   = 1'b0;
    bus.state_i = '0;
    test_reset();
    test_vectors();
    test_inverse();
    test_random();
    test_backpressure();
    test_midreset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
